// File: rtl/lsu_align_ctrl_pkg.sv
// Shared definitions for the LSU alignment controller: RV32 load/store funct3
// codes, the controller FSM states and access-size helpers.
package lsu_align_ctrl_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    // Byte count from the size field funct3[1:0]; 0 marks an unsupported size.
    function automatic logic [2:0] size_bytes(input logic [1:0] size_field);
        case (size_field)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            2'b10:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic is_legal(input logic we, input logic [2:0] funct3);
        if (we) begin
            return funct3 inside {SB, SH, SW};
        end
        return funct3 inside {LB, LH, LW, LBU, LHU};
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts a misaligned load from two consecutive memory words {hi,lo} at a
// byte offset and sign- or zero-extends it according to funct3.
module lsu_load_align
    import lsu_align_ctrl_pkg::*;
(
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;
    // The top byte of hi can never land inside a 32-bit window starting in lo.
    logic        unused_hi;

    assign unused_hi = ^hi[31:24];

    always_comb begin
        case (offset)
            2'd0:    shifted = lo;
            2'd1:    shifted = {hi[7:0],  lo[31:8]};
            2'd2:    shifted = {hi[15:0], lo[31:16]};
            default: shifted = {hi[23:0], lo[31:24]};
        endcase

        case (funct3)
            LB:      data = {{24{shifted[7]}}, shifted[7:0]};
            LBU:     data = {24'b0, shifted[7:0]};
            LH:      data = {{16{shifted[15]}}, shifted[15:0]};
            LHU:     data = {16'b0, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_align_ctrl.sv
// Load/store alignment controller between execute and a word-organised memory.
// Define LSU_MISALIGNED_EN to split misaligned accesses; otherwise they are errors.
module lsu_align_ctrl
    import lsu_align_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_wr_en,
    output logic [2:0]            mem_funct3,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [2:0]            req_size;
    logic                  req_misal;
    logic                  req_bad;
    logic                  last_beat;
    logic [DATA_WIDTH-1:0] load_data;

    assign req_size  = size_bytes(req_funct3[1:0]);
    assign req_misal = (req_size == 3'd2 && req_addr[0]) ||
                       (req_size == 3'd4 && req_addr[1:0] != 2'b00);

`ifdef LSU_MISALIGNED_EN
    logic [1:0]            beat_q, beat_d;
    logic [1:0]            last_q, last_d;
    logic                  split_q, split_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic [DATA_WIDTH-1:0] split_data;

    // The second word of a split load comes straight from memory on the last beat.
    lsu_load_align u_load_align (
        .hi     (mem_rd_data),
        .lo     (lo_q),
        .offset (addr_q[1:0]),
        .funct3 (funct3_q),
        .data   (split_data)
    );

    assign req_bad   = !is_legal(req_we, req_funct3);
    assign last_beat = (beat_q == last_q);
    assign load_data = split_q ? split_data : mem_rd_data;
`else
    assign req_bad   = !is_legal(req_we, req_funct3) || req_misal;
    assign last_beat = 1'b1;
    assign load_data = mem_rd_data;
`endif

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no latch is inferred.
        mem_wr_en   = 1'b0;
        mem_funct3  = LW;
        mem_addr    = '0;
        mem_wr_data = '0;
        if (state_q == ACCESS) begin
            // Gating with rst_n abandons the beat in the cycle reset is sampled.
            mem_wr_en   = we_q && rst_n;
            mem_funct3  = funct3_q;
            mem_addr    = addr_q;
            mem_wr_data = wdata_q;
`ifdef LSU_MISALIGNED_EN
            if (split_q) begin
                if (we_q) begin
                    mem_funct3  = SB;
                    mem_addr    = addr_q + ADDR_WIDTH'(beat_q);
                    mem_wr_data = DATA_WIDTH'(wdata_q[8*beat_q +: 8]);
                end else begin
                    mem_funct3  = LW;
                    mem_addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00} + ADDR_WIDTH'({beat_q[0], 2'b00});
                    mem_wr_data = '0;
                end
            end
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
`ifdef LSU_MISALIGNED_EN
        beat_d   = beat_q;
        last_d   = last_q;
        split_d  = split_q;
        lo_d     = lo_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
`ifdef LSU_MISALIGNED_EN
                    beat_d   = 2'd0;
                    split_d  = req_misal;
                    last_d   = !req_misal ? 2'd0 : (req_we && req_size[2]) ? 2'd3 : 2'd1;
`endif
                    if (req_bad) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (last_beat) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = we_q ? '0 : load_data;
                end
`ifdef LSU_MISALIGNED_EN
                else begin
                    beat_d = beat_q + 2'd1;
                end
                if (beat_q == 2'd0) begin
                    lo_d = mem_rd_data;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only; blocking belongs in always_comb.
        if (!rst_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
`ifdef LSU_MISALIGNED_EN
            beat_q   <= 2'd0;
            last_q   <= 2'd0;
            split_q  <= 1'b0;
            lo_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
`ifdef LSU_MISALIGNED_EN
            beat_q   <= beat_d;
            last_q   <= last_d;
            split_q  <= split_d;
            lo_q     <= lo_d;
`endif
        end
    end

endmodule

// File: tb/tb_lsu_align_ctrl.sv
// Self-checking bench for lsu_align_ctrl: directed vector table, hand-written
// reset/wrap sequences and random requests against a byte-level memory model.
module tb_lsu_align_ctrl;

`ifdef LSU_MISALIGNED_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_wr_en;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    always #5 clk = ~clk;

    lsu_align_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .mem_wr_en   (mem_wr_en),
        .mem_funct3  (mem_funct3),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data)
    );

    // 256-byte memory aliased over the whole address space (low 8 address bits).
    logic [7:0]  dmem [256];
    logic [7:0]  rmem [256];
    logic [7:0]  rd_a;
    logic [31:0] rd_w;

    always_comb begin
        rd_a = mem_addr[7:0];
        rd_w = {dmem[8'(rd_a + 8'd3)], dmem[8'(rd_a + 8'd2)], dmem[8'(rd_a + 8'd1)], dmem[rd_a]};
        case (mem_funct3)
            3'b000:  mem_rd_data = {{24{rd_w[7]}}, rd_w[7:0]};
            3'b001:  mem_rd_data = {{16{rd_w[15]}}, rd_w[15:0]};
            3'b100:  mem_rd_data = {24'b0, rd_w[7:0]};
            3'b101:  mem_rd_data = {16'b0, rd_w[15:0]};
            default: mem_rd_data = rd_w;
        endcase
    end

    always @(posedge clk) begin
        if (mem_wr_en === 1'b1) begin
            dmem[mem_addr[7:0]] <= mem_wr_data[7:0];
            if (mem_funct3[1:0] != 2'b00) dmem[8'(mem_addr[7:0] + 8'd1)] <= mem_wr_data[15:8];
            if (mem_funct3[1:0] == 2'b10) begin
                dmem[8'(mem_addr[7:0] + 8'd2)] <= mem_wr_data[23:16];
                dmem[8'(mem_addr[7:0] + 8'd3)] <= mem_wr_data[31:24];
            end
        end
    end

    typedef struct packed {
        logic        wr_en;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] mask;
    } beat_t;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          n;
        string       name;
    } vec_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t exp_beats[$];
    vec_t  tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic poke_word(input logic [7:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            dmem[8'(a + 8'(i))] = w[8*i +: 8];
            rmem[8'(a + 8'(i))] = w[8*i +: 8];
        end
    endtask

    // Reference: describes an access as a list of bytes, independent of beat mechanics.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] exp_rdata, output logic exp_err);
        int          size;
        bit          legal;
        bit          misal;
        logic [31:0] v;
        logic [31:0] m;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        misal = legal ? ((addr % 32'(size)) != 0) : 1'b0;
        m     = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*size)) - 32'h1);
        exp_beats.delete();
        exp_rdata = 32'h0;
        exp_err   = !legal || (misal && !MIS_EN);
        if (exp_err) return;
        if (!misal) begin
            exp_beats.push_back('{we, f3, addr, wdata & m, m});
        end else if (!we) begin
            for (int i = 0; i < 2; i++)
                exp_beats.push_back('{1'b0, 3'b010, (addr & ~32'h3) + 32'(4*i), 32'h0, 32'h0});
        end else begin
            for (int i = 0; i < size; i++)
                exp_beats.push_back('{1'b1, 3'b000, addr + 32'(i), (wdata >> (8*i)) & 32'hFF, 32'hFFFF_FFFF});
        end
        if (we) begin
            for (int i = 0; i < size; i++) rmem[8'(addr + 32'(i))] = 8'(wdata >> (8*i));
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v |= 32'(rmem[8'(addr + 32'(i))]) << (8*i);
            if (!f3[2] && size < 4 && v[8*size-1]) v |= ~m;
            exp_rdata = v;
        end
    endtask

    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] got_rdata,
                           output logic got_err, output int got_n);
        beat_t       act[$];
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          n;
        model(we, f3, addr, wdata, exp_rdata, exp_err);
        n = 0;
        while (req_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("req_ready before request", req_ready, 1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(negedge clk);
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 8) begin
            act.push_back('{mem_wr_en, mem_funct3, mem_addr, mem_wr_data, 32'h0});
            @(negedge clk);
            n++;
        end
        got_n     = n;
        got_rdata = rsp_rdata;
        got_err   = rsp_err;
        check("rsp_valid within budget", rsp_valid, 1);
        check("beat count", n, exp_beats.size());
        for (int i = 0; i < act.size() && i < exp_beats.size(); i++) begin
            check("beat mem_wr_en", act[i].wr_en, exp_beats[i].wr_en);
            check("beat mem_funct3", act[i].f3, exp_beats[i].f3);
            check("beat mem_addr", act[i].addr, exp_beats[i].addr);
            if (exp_beats[i].wr_en)
                check("beat mem_wr_data", act[i].data & exp_beats[i].mask, exp_beats[i].data);
        end
        check("rsp_err", rsp_err, exp_err);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("req_ready low during response", req_ready, 0);
        @(negedge clk);
        check("rsp_valid single cycle", rsp_valid, 0);
        check("rsp_rdata held", rsp_rdata, exp_rdata);
        check("req_ready after response", req_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          nb;
        int          bad;
        bit          saw;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        for (int i = 0; i < 256; i++) begin
            dmem[i] = 8'($urandom);
            rmem[i] = dmem[i];
        end

        repeat (3) @(negedge clk);
        check("reset req_ready", req_ready, 1);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_rdata", rsp_rdata, 0);
        check("reset rsp_err", rsp_err, 0);
        check("reset mem_wr_en", mem_wr_en, 0);
        check("reset mem_funct3", mem_funct3, 3'b010);
        check("reset mem_addr", mem_addr, 0);
        check("reset mem_wr_data", mem_wr_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        poke_word(8'h10, 32'h8040_2010);
        poke_word(8'h14, 32'h1234_56F1);
        poke_word(8'h30, 32'h0000_0000);

        tbl.push_back('{1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h8040_2010, 1, "lw aligned"});
        tbl.push_back('{1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'hFFFF_FF80, 1, "lb sign"});
        tbl.push_back('{1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 32'h0000_0080, 1, "lbu zero"});
        tbl.push_back('{1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'hFFFF_8040, 1, "lh sign"});
        tbl.push_back('{1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 32'h0000_8040, 1, "lhu zero"});
        tbl.push_back('{1'b0, 3'b000, 32'h11, 32'h0, 1'b0, 32'h0000_0020, 1, "lb positive"});
        tbl.push_back('{1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 0, "load f3 011"});
        tbl.push_back('{1'b0, 3'b110, 32'h10, 32'h0, 1'b1, 32'h0, 0, "load f3 110"});
        tbl.push_back('{1'b1, 3'b100, 32'h30, 32'hFFFF_FFFF, 1'b1, 32'h0, 0, "store f3 100"});
        tbl.push_back('{1'b1, 3'b001, 32'h30, 32'h1234_ABCD, 1'b0, 32'h0, 1, "sh aligned"});
        tbl.push_back('{1'b1, 3'b000, 32'h33, 32'hFFFF_FF5A, 1'b0, 32'h0, 1, "sb aligned"});
        tbl.push_back('{1'b0, 3'b010, 32'h30, 32'h0, 1'b0, 32'h5A00_ABCD, 1, "lw after sh sb"});
        tbl.push_back('{1'b0, 3'b001, 32'h13, 32'h0, !MIS_EN, MIS_EN ? 32'hFFFF_F180 : 32'h0,
                        MIS_EN ? 2 : 0, "lh misaligned"});
        tbl.push_back('{1'b0, 3'b101, 32'h13, 32'h0, !MIS_EN, MIS_EN ? 32'h0000_F180 : 32'h0,
                        MIS_EN ? 2 : 0, "lhu misaligned"});
        tbl.push_back('{1'b0, 3'b010, 32'h11, 32'h0, !MIS_EN, MIS_EN ? 32'hF180_4020 : 32'h0,
                        MIS_EN ? 2 : 0, "lw misaligned"});
        tbl.push_back('{1'b1, 3'b001, 32'h31, 32'h0000_BEEF, !MIS_EN, 32'h0,
                        MIS_EN ? 2 : 0, "sh misaligned"});
        tbl.push_back('{1'b0, 3'b010, 32'h30, 32'h0, 1'b0, MIS_EN ? 32'h5ABE_EFCD : 32'h5A00_ABCD,
                        1, "lw after sh misaligned"});

        foreach (tbl[k]) begin
            run_req(tbl[k].we, tbl[k].f3, tbl[k].addr, tbl[k].wdata, rd, er, nb);
            check({tbl[k].name, " rdata"}, rd, tbl[k].rdata);
            check({tbl[k].name, " err"}, er, tbl[k].err);
            check({tbl[k].name, " beats"}, nb, tbl[k].n);
        end

        // Misaligned word store, then read back the covering words.
        poke_word(8'h20, 32'h0);
        poke_word(8'h24, 32'h0);
        run_req(1'b1, 3'b010, 32'h21, 32'hAABB_CCDD, rd, er, nb);
        check("sw 0x21 err", er, !MIS_EN);
        check("sw 0x21 beats", nb, MIS_EN ? 4 : 0);
        run_req(1'b0, 3'b010, 32'h20, 32'h0, rd, er, nb);
        check("lw 0x20 after sw 0x21", rd[31:8], MIS_EN ? 32'hBB_CCDD : 32'h0);
        run_req(1'b0, 3'b010, 32'h24, 32'h0, rd, er, nb);
        check("lw 0x24 after sw 0x21", rd, MIS_EN ? 32'hAA : 32'h0);

        // Misaligned word load wrapping past the top of the address space.
        poke_word(8'hFC, 32'h4433_2211);
        poke_word(8'h00, 32'h8877_6655);
        run_req(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, rd, er, nb);
        check("lw wrap rdata", rd, MIS_EN ? 32'h6655_4433 : 32'h0);
        check("lw wrap err", er, !MIS_EN);

        // Reset during a store: the beat in the reset cycle and all later ones are dropped.
        poke_word(8'h40, 32'h0);
        poke_word(8'h44, 32'h0);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = MIS_EN ? 32'h41 : 32'h40;
        req_wdata  = 32'h1122_3344;
        @(negedge clk);
        req_valid = 1'b0;
        if (MIS_EN) repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid-access reset req_ready", req_ready, 1);
        check("mid-access reset rsp_valid", rsp_valid, 0);
        check("mid-access reset rsp_rdata", rsp_rdata, 0);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) saw = 1'b1;
        end
        check("no response after reset", saw, 0);
        if (MIS_EN) begin
            rmem[8'h41] = 8'h44;
            rmem[8'h42] = 8'h33;
        end
        for (int i = 8'h40; i < 8'h48; i++) check("bytes after reset", dmem[i], rmem[i]);

        for (int t = 0; t < 300; t++) begin
            we    = 1'($urandom);
            f3    = 3'($urandom);
            if ($urandom_range(0, 1) == 0) f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2));
            addr  = $urandom;
            wdata = $urandom;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_req(we, f3, addr, wdata, rd, er, nb);
        end

        bad = 0;
        for (int i = 0; i < 256; i++) if (dmem[i] !== rmem[i]) bad++;
        check("final memory image mismatching bytes", bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
